// File: rtl/rr_read_port_arbiter_if.sv
// Request/response bundle between issue-queue select and the PRF read-port arbiter.
// Master is the issue side; slave is the arbiter.
interface rr_read_port_arbiter_if #(
    parameter int NUM_LANES    = 4,
    parameter int NUM_RD_PORTS = 4,
    parameter int PHY_LOG      = 7,
    parameter int PORT_LOG     = $clog2(NUM_RD_PORTS)
);
    logic [NUM_LANES-1:0]            reqValid_i;
    logic [NUM_LANES-1:0]            src1Valid_i;
    logic [NUM_LANES-1:0]            src2Valid_i;
    logic [NUM_LANES*PHY_LOG-1:0]    phySrc1_i;
    logic [NUM_LANES*PHY_LOG-1:0]    phySrc2_i;
    logic [NUM_LANES-1:0]            grant_o;
    logic [NUM_RD_PORTS-1:0]         rdEn_o;
    logic [NUM_RD_PORTS*PHY_LOG-1:0] rdAddr_o;
    logic [NUM_LANES*PORT_LOG-1:0]   src1Port_o;
    logic [NUM_LANES*PORT_LOG-1:0]   src2Port_o;
    logic [15:0]                     stallCycles_o;

    modport master (
        output reqValid_i, src1Valid_i, src2Valid_i, phySrc1_i, phySrc2_i,
        input  grant_o, rdEn_o, rdAddr_o, src1Port_o, src2Port_o, stallCycles_o
    );

    modport slave (
        input  reqValid_i, src1Valid_i, src2Valid_i, phySrc1_i, phySrc2_i,
        output grant_o, rdEn_o, rdAddr_o, src1Port_o, src2Port_o, stallCycles_o
    );
endinterface

// File: rtl/rr_read_port_arbiter.sv
// Round-robin, in-order allocation of shared PRF read ports to issue lanes.
// Optional RR_PORT_SHARE_EN lets operands with an already-allocated tag reuse that port.
module rr_read_port_arbiter #(
    parameter int NUM_LANES    = 4,
    parameter int NUM_RD_PORTS = 4,
    parameter int PHY_LOG      = 7,
    parameter int LANE_LOG     = $clog2(NUM_LANES),
    parameter int PORT_LOG     = $clog2(NUM_RD_PORTS)
) (
    input logic clk,
    input logic reset,
    input logic recoverFlag_i,
    rr_read_port_arbiter_if.slave bus
);
    localparam logic [LANE_LOG:0]   N_LANES  = (LANE_LOG+1)'(NUM_LANES);
    localparam logic [PORT_LOG:0]   N_PORTS  = (PORT_LOG+1)'(NUM_RD_PORTS);
    localparam logic [LANE_LOG-1:0] LANE_MAX = LANE_LOG'(NUM_LANES - 1);

    logic [NUM_LANES-1:0][PHY_LOG-1:0] tag1, tag2;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_tags
        assign tag1[gi] = bus.phySrc1_i[gi*PHY_LOG +: PHY_LOG];
        assign tag2[gi] = bus.phySrc2_i[gi*PHY_LOG +: PHY_LOG];
    end

    logic [NUM_LANES-1:0]                 grant_d, grant_q;
    logic [NUM_RD_PORTS-1:0]              rd_en_d, rd_en_q;
    logic [NUM_RD_PORTS-1:0][PHY_LOG-1:0] rd_addr_d, rd_addr_q;
    logic [NUM_LANES-1:0][PORT_LOG-1:0]   src1_port_d, src1_port_q;
    logic [NUM_LANES-1:0][PORT_LOG-1:0]   src2_port_d, src2_port_q;
    logic [LANE_LOG-1:0]                  ptr_q, block_idx;
    logic [15:0]                          stall_q;
    logic                                 stop;

    logic [PORT_LOG:0]   used, k;
    logic [LANE_LOG:0]   lane_sum;
    logic [LANE_LOG-1:0] ln;
    logic                n1, n2, m1, m2, dup;
    logic [PORT_LOG-1:0] p1, p2;

    always_comb begin
        grant_d     = '0;
        rd_en_d     = '0;
        rd_addr_d   = '0;
        src1_port_d = '0;
        src2_port_d = '0;
        stop        = 1'b0;
        block_idx   = '0;
        used        = '0;
        k           = '0;
        lane_sum    = '0;
        ln          = '0;
        n1 = 1'b0; n2 = 1'b0; m1 = 1'b0; m2 = 1'b0; dup = 1'b0;
        p1 = '0;   p2 = '0;
        for (logic [LANE_LOG:0] off = '0; off < N_LANES; off++) begin
            lane_sum = {1'b0, ptr_q} + off;
            if (lane_sum >= N_LANES) lane_sum = lane_sum - N_LANES;
            ln = lane_sum[LANE_LOG-1:0];
            if (!stop && bus.reqValid_i[ln]) begin
                m1 = 1'b0; m2 = 1'b0; p1 = '0; p2 = '0;
`ifdef RR_PORT_SHARE_EN
                // Match only against ports handed out earlier in this scan.
                for (logic [PORT_LOG:0] p = '0; p < N_PORTS; p++) begin
                    if (bus.src1Valid_i[ln] && !m1 && rd_en_d[p[PORT_LOG-1:0]] &&
                        rd_addr_d[p[PORT_LOG-1:0]] == tag1[ln]) begin
                        m1 = 1'b1; p1 = p[PORT_LOG-1:0];
                    end
                    if (bus.src2Valid_i[ln] && !m2 && rd_en_d[p[PORT_LOG-1:0]] &&
                        rd_addr_d[p[PORT_LOG-1:0]] == tag2[ln]) begin
                        m2 = 1'b1; p2 = p[PORT_LOG-1:0];
                    end
                end
                n1  = bus.src1Valid_i[ln] && !m1;
                dup = bus.src2Valid_i[ln] && !m2 && n1 && (tag2[ln] == tag1[ln]);
                n2  = bus.src2Valid_i[ln] && !m2 && !dup;
`else
                dup = 1'b0;
                n1  = bus.src1Valid_i[ln];
                n2  = bus.src2Valid_i[ln];
`endif
                k = (PORT_LOG+1)'(n1) + (PORT_LOG+1)'(n2);
                if (k <= N_PORTS - used) begin
                    grant_d[ln] = 1'b1;
                    if (n1) begin
                        rd_en_d[used[PORT_LOG-1:0]]   = 1'b1;
                        rd_addr_d[used[PORT_LOG-1:0]] = tag1[ln];
                        src1_port_d[ln]               = used[PORT_LOG-1:0];
                        used                          = used + 1'b1;
                    end else if (m1) begin
                        src1_port_d[ln] = p1;
                    end
                    if (dup) begin
                        src2_port_d[ln] = src1_port_d[ln];
                    end else if (n2) begin
                        rd_en_d[used[PORT_LOG-1:0]]   = 1'b1;
                        rd_addr_d[used[PORT_LOG-1:0]] = tag2[ln];
                        src2_port_d[ln]               = used[PORT_LOG-1:0];
                        used                          = used + 1'b1;
                    end else if (m2) begin
                        src2_port_d[ln] = p2;
                    end
                end else begin
                    stop      = 1'b1;
                    block_idx = ln;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= '0;
            rd_en_q     <= '0;
            rd_addr_q   <= '0;
            src1_port_q <= '0;
            src2_port_q <= '0;
            ptr_q       <= '0;
            stall_q     <= '0;
        end else if (recoverFlag_i) begin
            // Flush drops this cycle's grants but keeps the stall history.
            grant_q     <= '0;
            rd_en_q     <= '0;
            rd_addr_q   <= '0;
            src1_port_q <= '0;
            src2_port_q <= '0;
            ptr_q       <= '0;
        end else begin
            grant_q     <= grant_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            src1_port_q <= src1_port_d;
            src2_port_q <= src2_port_d;
            if (|bus.reqValid_i) begin
                if (stop)                   ptr_q <= block_idx;
                else if (ptr_q == LANE_MAX) ptr_q <= '0;
                else                        ptr_q <= ptr_q + 1'b1;
            end
            if (stop && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.rdEn_o        = rd_en_q;
    assign bus.rdAddr_o      = rd_addr_q;
    assign bus.src1Port_o    = src1_port_q;
    assign bus.src2Port_o    = src2_port_q;
    assign bus.stallCycles_o = stall_q;
endmodule

// File: tb/tb_rr_read_port_arbiter.sv
// Directed bench for rr_read_port_arbiter: one task per scenario, hand-computed expectations.
// Expectations for the all-same-tag case follow RR_PORT_SHARE_EN.
module tb_rr_read_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic recover = 1'b0;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    rr_read_port_arbiter_if #(.NUM_LANES(4), .NUM_RD_PORTS(4), .PHY_LOG(7)) bus ();

    rr_read_port_arbiter #(.NUM_LANES(4), .NUM_RD_PORTS(4), .PHY_LOG(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .recoverFlag_i (recover),
        .bus           (bus)
    );

    // Default tags: lane n src1 = 10+n, src2 = 20+n.
    task automatic drive(input logic [3:0] req, input logic [3:0] s1, input logic [3:0] s2);
        bus.reqValid_i  = req;
        bus.src1Valid_i = s1;
        bus.src2Valid_i = s2;
        for (int i = 0; i < 4; i++) begin
            bus.phySrc1_i[i*7 +: 7] = 7'(10 + i);
            bus.phySrc2_i[i*7 +: 7] = 7'(20 + i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(4'hF, 4'hF, 4'hF);
        do_reset();
        total_cnt++; if (bus.grant_o !== 4'h0) $display("FAIL reset_grant got %h want 0", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdEn_o !== 4'h0) $display("FAIL reset_rden got %h want 0", bus.rdEn_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== 28'h0) $display("FAIL reset_addr got %h want 0", bus.rdAddr_o); else pass_cnt++;
        total_cnt++; if ({bus.src1Port_o, bus.src2Port_o} !== 16'h0) $display("FAIL reset_ports got %h want 0", {bus.src1Port_o, bus.src2Port_o}); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'h0) $display("FAIL reset_stall got %h want 0", bus.stallCycles_o); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_full_then_tail();
        drive(4'hF, 4'hF, 4'hF);
        step();
        $display("full req: grant=%b rdEn=%b stall=%0d", bus.grant_o, bus.rdEn_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'b0011) $display("FAIL full_grant got %b want 0011", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdEn_o !== 4'b1111) $display("FAIL full_rden got %b want 1111", bus.rdEn_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== {7'd21, 7'd11, 7'd20, 7'd10}) $display("FAIL full_addr got %h want %h", bus.rdAddr_o, {7'd21, 7'd11, 7'd20, 7'd10}); else pass_cnt++;
        total_cnt++; if (bus.src1Port_o !== 8'h08) $display("FAIL full_src1port got %h want 08", bus.src1Port_o); else pass_cnt++;
        total_cnt++; if (bus.src2Port_o !== 8'h0D) $display("FAIL full_src2port got %h want 0d", bus.src2Port_o); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'd1) $display("FAIL full_stall got %0d want 1", bus.stallCycles_o); else pass_cnt++;
        drive(4'b1100, 4'hF, 4'hF);
        step();
        $display("tail req: grant=%b stall=%0d", bus.grant_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'b1100) $display("FAIL tail_grant got %b want 1100", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.src1Port_o !== 8'h80) $display("FAIL tail_src1port got %h want 80", bus.src1Port_o); else pass_cnt++;
        total_cnt++; if (bus.src2Port_o !== 8'hD0) $display("FAIL tail_src2port got %h want d0", bus.src2Port_o); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'd1) $display("FAIL tail_stall got %0d want 1", bus.stallCycles_o); else pass_cnt++;
        drive(4'h0, 4'h0, 4'h0);
        step();
        total_cnt++; if (bus.grant_o !== 4'h0 || bus.rdEn_o !== 4'h0) $display("FAIL idle_out got %b/%b want 0/0", bus.grant_o, bus.rdEn_o); else pass_cnt++;
    endtask

    task automatic test_zero_need_lane();
        do_reset();
        drive(4'hF, 4'b1101, 4'b1101);
        step();
        $display("k0 lane: grant=%b stall=%0d", bus.grant_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'b0111) $display("FAIL k0_grant got %b want 0111", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== {7'd22, 7'd12, 7'd20, 7'd10}) $display("FAIL k0_addr got %h want %h", bus.rdAddr_o, {7'd22, 7'd12, 7'd20, 7'd10}); else pass_cnt++;
        total_cnt++; if (bus.src1Port_o !== 8'h20 || bus.src2Port_o !== 8'h31) $display("FAIL k0_ports got %h/%h want 20/31", bus.src1Port_o, bus.src2Port_o); else pass_cnt++;
        // Blocked lane 3 must be scanned first next cycle.
        drive(4'hF, 4'hF, 4'hF);
        step();
        $display("after block: grant=%b stall=%0d", bus.grant_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'b1001) $display("FAIL ptr3_grant got %b want 1001", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== {7'd20, 7'd10, 7'd23, 7'd13}) $display("FAIL ptr3_addr got %h want %h", bus.rdAddr_o, {7'd20, 7'd10, 7'd23, 7'd13}); else pass_cnt++;
        total_cnt++; if (bus.src1Port_o !== 8'h02 || bus.src2Port_o !== 8'h43) $display("FAIL ptr3_ports got %h/%h want 02/43", bus.src1Port_o, bus.src2Port_o); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'd2) $display("FAIL ptr3_stall got %0d want 2", bus.stallCycles_o); else pass_cnt++;
    endtask

    task automatic test_single_operands();
        do_reset();
        drive(4'hF, 4'b1101, 4'b0110);
        step();
        $display("single ops: grant=%b", bus.grant_o);
        total_cnt++; if (bus.grant_o !== 4'b0111) $display("FAIL single_grant got %b want 0111", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== {7'd22, 7'd12, 7'd21, 7'd10}) $display("FAIL single_addr got %h want %h", bus.rdAddr_o, {7'd22, 7'd12, 7'd21, 7'd10}); else pass_cnt++;
        total_cnt++; if (bus.src1Port_o !== 8'h20 || bus.src2Port_o !== 8'h34) $display("FAIL single_ports got %h/%h want 20/34", bus.src1Port_o, bus.src2Port_o); else pass_cnt++;
    endtask

    task automatic test_recover();
        logic [15:0] stall_before;
        do_reset();
        drive(4'hF, 4'hF, 4'hF);
        step();
        stall_before = bus.stallCycles_o;
        drive(4'hF, 4'hF, 4'hF);
        recover = 1'b1;
        step();
        recover = 1'b0;
        $display("recover: grant=%b stall=%0d", bus.grant_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'h0 || bus.rdEn_o !== 4'h0) $display("FAIL recover_out got %b/%b want 0/0", bus.grant_o, bus.rdEn_o); else pass_cnt++;
        total_cnt++; if ({bus.src1Port_o, bus.src2Port_o} !== 16'h0) $display("FAIL recover_ports got %h want 0", {bus.src1Port_o, bus.src2Port_o}); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'd1 || stall_before !== 16'd1) $display("FAIL recover_stall got %0d want 1", bus.stallCycles_o); else pass_cnt++;
        step();
        $display("post recover: grant=%b stall=%0d", bus.grant_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'b0011) $display("FAIL restart_grant got %b want 0011", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'd2) $display("FAIL restart_stall got %0d want 2", bus.stallCycles_o); else pass_cnt++;
    endtask

    task automatic test_same_tag();
        do_reset();
        drive(4'hF, 4'hF, 4'hF);
        bus.phySrc1_i = {4{7'd5}};
        bus.phySrc2_i = {4{7'd5}};
        step();
        $display("same tag: grant=%b rdEn=%b", bus.grant_o, bus.rdEn_o);
`ifdef RR_PORT_SHARE_EN
        total_cnt++; if (bus.grant_o !== 4'b1111) $display("FAIL share_grant got %b want 1111", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdEn_o !== 4'b0001) $display("FAIL share_rden got %b want 0001", bus.rdEn_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== 28'd5) $display("FAIL share_addr got %h want 5", bus.rdAddr_o); else pass_cnt++;
        total_cnt++; if ({bus.src1Port_o, bus.src2Port_o} !== 16'h0) $display("FAIL share_ports got %h want 0", {bus.src1Port_o, bus.src2Port_o}); else pass_cnt++;
`else
        total_cnt++; if (bus.grant_o !== 4'b0011) $display("FAIL noshare_grant got %b want 0011", bus.grant_o); else pass_cnt++;
        total_cnt++; if (bus.rdEn_o !== 4'b1111) $display("FAIL noshare_rden got %b want 1111", bus.rdEn_o); else pass_cnt++;
        total_cnt++; if (bus.rdAddr_o !== {4{7'd5}}) $display("FAIL noshare_addr got %h want %h", bus.rdAddr_o, {4{7'd5}}); else pass_cnt++;
        total_cnt++; if (bus.src1Port_o !== 8'h08 || bus.src2Port_o !== 8'h0D) $display("FAIL noshare_ports got %h/%h want 08/0d", bus.src1Port_o, bus.src2Port_o); else pass_cnt++;
`endif
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        drive(4'hF, 4'hF, 4'hF);
        repeat (70000) @(posedge clk);
        #1;
        $display("saturation: stall=%h", bus.stallCycles_o);
        total_cnt++; if (bus.stallCycles_o !== 16'hFFFF) $display("FAIL sat_stall got %h want ffff", bus.stallCycles_o); else pass_cnt++;
        step();
        total_cnt++; if (bus.stallCycles_o !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", bus.stallCycles_o); else pass_cnt++;
        reset = 1'b1;
        step();
        $display("midstream reset: grant=%b stall=%h", bus.grant_o, bus.stallCycles_o);
        total_cnt++; if (bus.grant_o !== 4'h0 || bus.rdEn_o !== 4'h0 || bus.rdAddr_o !== 28'h0) $display("FAIL mreset_out got %b/%b/%h want 0", bus.grant_o, bus.rdEn_o, bus.rdAddr_o); else pass_cnt++;
        total_cnt++; if (bus.stallCycles_o !== 16'h0) $display("FAIL mreset_stall got %h want 0", bus.stallCycles_o); else pass_cnt++;
        reset = 1'b0;
        drive(4'h0, 4'h0, 4'h0);
        step();
        total_cnt++; if (bus.grant_o !== 4'h0 || {bus.src1Port_o, bus.src2Port_o} !== 16'h0) $display("FAIL post_reset_grant got %b want 0", bus.grant_o); else pass_cnt++;
    endtask

    initial begin
        drive(4'h0, 4'h0, 4'h0);
        test_reset();
        test_full_then_tail();
        test_zero_need_lane();
        test_single_operands();
        test_recover();
        test_same_tag();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
